booth_seq_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier, parametrised in operand width, with a per-operation signed/unsigned mode and valid/ready handshakes on both sides. It trades area for latency: one shared (N+2)-bit add/subtract datapath is reused for N+1 iterations. It sits in the integer/mantissa multiply path of the FPU as the successor to the purely combinational add-shift adder chain.

---
 rtl/booth_seq_multiplier_pkg.sv | 13 +
 rtl/booth_seq_multiplier_if.sv | 28 ++
 rtl/booth_seq_multiplier_addsub.sv | 28 ++
 rtl/booth_seq_multiplier.sv | 106 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types for the sequential Booth multiplier.
//   mult_state_t : FSM state encoding (IDLE, CALC, DONE)
//   cnt_w(n)     : width of the iteration counter for an n-bit operand,
//                  sized to hold n+1 with headroom
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Handshake bundle for booth_seq_multiplier.
//   in_valid/in_ready   : operand handshake (a, b, is_signed)
//   out_valid/out_ready : result handshake (product, 2N bits)
//   busy                : block is in CALC or DONE
//   master : producer/consumer side, slave : multiplier side
interface booth_seq_multiplier_if #(parameter int N = 32);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   product;
  logic             busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/booth_seq_multiplier_addsub.sv
// Ripple-carry add/subtract unit shared by every Booth iteration.
//   x, y : operands (WIDTH bits)
//   sub  : 0 -> x+y, 1 -> x+~y+1 (doubles as carry-in)
//   sum  : WIDTH-bit result, carry-out discarded
module booth_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] c;

  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic yb;
    assign yb     = y[i] ^ sub;
    assign sum[i] = x[i] ^ yb ^ c[i];
    // Top cell's carry-out is never needed.
    if (i < WIDTH - 1) begin : g_carry
      assign c[i+1] = (x[i] & yb) | (c[i] & (x[i] ^ yb));
    end
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one add/sub step per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of booth_seq_multiplier_if (operands in,
//                2N-bit product out, busy status)
// Operands are extended to N+1 bits so signed and unsigned share one
// signed datapath; the accumulator carries one extra guard bit so A+-M
// never overflows. Result appears N+1 cycles after acceptance.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_seq_multiplier_if.slave bus
);

  localparam int W  = N + 1;
  localparam int CW = cnt_w(N);

  mult_state_t    state;
  logic [W:0]     acc;
  logic [W:0]     mcand;
  logic [W-1:0]   q;
  logic           q_m1;
  logic [CW-1:0]  cnt;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [2*N-1:0] product_q;

  logic [W-1:0]   a_ext, b_ext;
  logic [W:0]     sum, acc_op, acc_sh;
  logic [W-1:0]   q_sh;

  // Extension bit is the sign only in signed mode.
  assign a_ext = {bus.is_signed & bus.a[N-1], bus.a};
  assign b_ext = {bus.is_signed & bus.b[N-1], bus.b};

  // Booth pair 10 subtracts, 01 adds, so Q[0] selects the operation.
  booth_addsub #(.WIDTH(W + 1)) u_addsub (
    .x   (acc),
    .y   (mcand),
    .sub (q[0]),
    .sum (sum)
  );

  always_comb begin
    acc_op = (q[0] ^ q_m1) ? sum : acc;
    acc_sh = {acc_op[W], acc_op[W:1]};
    q_sh   = {acc_op[0], q[W-1:1]};
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= {a_ext[W-1], a_ext};
            acc        <= '0;
            q          <= b_ext;
            q_m1       <= 1'b0;
            cnt        <= CW'(W);
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_sh;
          q    <= q_sh;
          q_m1 <= q[0];
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            // Capture from the post-shift values of this final step.
            product_q   <= {acc_sh[N-2:0], q_sh};
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.N(N)) bus ();

  booth_seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands, wait for accept, measure latency, check result,
  // then complete the output handshake.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic [2*N-1:0] exp, input string tag);
    int lat;
    int guard;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.is_signed = s; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(N + 1));
    chk({tag, "_prod"}, 64'(bus.product), 64'(exp));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ovld_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [2*N-1:0] held;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_product", 64'(bus.product), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128");
    run_op(8'h07, 8'hFD, 1'b1, 16'hFFEB, "s7x-3");
    run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, "s-1x-1");
    run_op(8'h00, 8'hC8, 1'b0, 16'h0000, "u0x200");
    run_op(8'h7F, 8'h80, 1'b1, 16'hC080, "s127x-128");
    run_op(8'h80, 8'hFF, 1'b0, 16'h7F80, "u128x255");
    run_op(8'hC8, 8'h03, 1'b0, 16'h0258, "u200x3");
    run_op(8'hFB, 8'h06, 1'b1, 16'hFFE2, "s-5x6");

    // Back-pressure: 0x12*0x34 = 0x03A8, held for 20 cycles
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    held = bus.product;
    chk("bp_product", 64'(held), 64'h03A8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a = 8'(i * 7 + 1); bus.b = 8'(i * 3 + 2); bus.is_signed = i[0];
      @(posedge clk); #1;
      chk("bp_stable", 64'(bus.product), 64'(held));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_busy", 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_in_ready_pre", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_ovld", 64'(bus.out_valid), 64'd0);
    chk("bp_release_busy", 64'(bus.busy), 64'd0);

    // Reset mid-CALC after iteration 4
    @(negedge clk);
    bus.a = 8'h55; bus.b = 8'h77; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovld", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_prod", 64'(bus.product), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h03, 8'h05, 1'b0, 16'h000F, "post_rst_3x5");

    // Short mixed-mode sweep against integer arithmetic
    for (int i = 0; i < 16; i++) begin
      logic [N-1:0] ra, rb;
      logic rs;
      int ia, ib;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      ia = rs ? int'($signed(ra)) : int'(ra);
      ib = rs ? int'($signed(rb)) : int'(rb);
      run_op(ra, rb, rs, 16'(ia * ib), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
